// File: rtl/transport_pkg.sv
`default_nettype none
// ============================================================================
// Module   : transport_pkg
// Brief    : Shared type codes, header field widths and FSM state encodings
//            for the transport-layer transmit packetizer.
// Revision : 1.0  initial release
// ============================================================================
package transport_pkg;

    localparam int TYPE_W = 2;
    localparam int SEQ_W  = 6;

    localparam logic [TYPE_W-1:0] TYPE_CTRL  = 2'b01;
    localparam logic [TYPE_W-1:0] TYPE_AUDIO = 2'b10;

    typedef enum logic [1:0] {
        W_IDLE  = 2'd0,
        W_CTRL  = 2'd1,
        W_ACOPY = 2'd2
    } wstate_t;

    typedef enum logic [0:0] {
        R_IDLE = 1'b0,
        R_SEND = 1'b1
    } rstate_t;

    // Header byte: type code in the top two bits, per-type sequence below.
    function automatic logic [7:0] makeHeader(input logic [TYPE_W-1:0] typeCode,
                                              input logic [SEQ_W-1:0]  seq);
        return {typeCode, seq};
    endfunction

endpackage
`default_nettype wire

// File: rtl/sync_fifo_fwft.sv
`default_nettype none
// ============================================================================
// Module   : sync_fifo_fwft
// Brief    : Single-clock first-word-fall-through FIFO with synchronous reset.
//            The head entry is visible on o_rdData whenever o_empty is low.
//            DEPTH need not be a power of two.
// Revision : 1.0  initial release
// ============================================================================
module sync_fifo_fwft #(
    parameter  int DEPTH = 256,
    parameter  int WIDTH = 8,
    localparam int AW    = $clog2(DEPTH),
    localparam int CW    = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             srst,
    input  logic             i_wrEn,
    input  logic [WIDTH-1:0] i_wrData,
    input  logic             i_rdEn,
    output logic [WIDTH-1:0] o_rdData,
    output logic             o_empty,
    output logic             o_full,
    output logic [CW-1:0]    o_count
);

    localparam logic [AW-1:0] c_LAST_PTR = AW'(DEPTH - 1);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wrPtr;
    logic [AW-1:0]    r_rdPtr;
    logic [CW-1:0]    r_count;
    logic             w_wr;
    logic             w_rd;

    assign o_empty  = (r_count == '0);
    assign o_full   = (r_count == CW'(DEPTH));
    assign o_count  = r_count;
    assign o_rdData = r_mem[r_rdPtr];
    assign w_wr     = i_wrEn && !o_full;
    assign w_rd     = i_rdEn && !o_empty;

    // Storage array; contents are don't-care until written.
    always_ff @(posedge clk) begin
        if (w_wr) begin
            r_mem[r_wrPtr] <= i_wrData;
        end
    end

    // Pointers and occupancy, wrapping explicitly at DEPTH-1.
    always_ff @(posedge clk) begin
        if (srst) begin
            r_wrPtr <= '0;
            r_rdPtr <= '0;
            r_count <= '0;
        end else begin
            if (w_wr) begin
                r_wrPtr <= (r_wrPtr == c_LAST_PTR) ? '0 : r_wrPtr + AW'(1);
            end
            if (w_rd) begin
                r_rdPtr <= (r_rdPtr == c_LAST_PTR) ? '0 : r_rdPtr + AW'(1);
            end
            case ({w_wr, w_rd})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: rtl/transport_packetizer.sv
`default_nettype none
// ============================================================================
// Module   : transport_packetizer
// Brief    : Transmit packetizer. Builds fixed-size packets (type+sequence
//            header, payload, zero pad) from control/audio words, queues only
//            complete packets in a byte FIFO and streams them out byte-wise.
//            Optional macro TRANSPORT_CHECKSUM_EN: the last byte of every
//            packet becomes the XOR of all preceding bytes of that packet.
// Revision : 1.0  initial release
// ============================================================================
module transport_packetizer
    import transport_pkg::*;
#(
    parameter int PKT_BYTES  = 16,
    parameter int DATA_W     = 16,
    parameter int FIFO_BYTES = 256
) (
    input  logic                                       clk,
    input  logic                                       reset,
    input  logic                                       in_valid,
    output logic                                       in_ready,
    input  logic [1:0]                                 in_type,
    input  logic [DATA_W-1:0]                          in_data,
    input  logic                                       audio_flush,
    input  logic                                       tx_en,
    output logic [7:0]                                 out_data,
    output logic                                       out_valid,
    input  logic                                       out_ready,
    output logic                                       out_sop,
    output logic                                       out_eop,
    output logic [$clog2(FIFO_BYTES/PKT_BYTES+1)-1:0]  pkt_count,
    output logic                                       busy
);

    localparam int c_WB = DATA_W / 8;
`ifdef TRANSPORT_CHECKSUM_EN
    localparam int c_P  = PKT_BYTES - 2;
`else
    localparam int c_P  = PKT_BYTES - 1;
`endif
    localparam int c_IDX_W  = $clog2(PKT_BYTES);
    localparam int c_FILL_W = $clog2(c_P + 1);
    localparam int c_CNT_W  = $clog2(FIFO_BYTES / PKT_BYTES + 1);
    localparam int c_FCNT_W = $clog2(FIFO_BYTES + 1);
    localparam logic [c_IDX_W-1:0] c_LAST_IDX = c_IDX_W'(PKT_BYTES - 1);

    wstate_t               r_wstate, w_wnext;
    rstate_t               r_rstate, w_rnext;
    logic [c_IDX_W-1:0]    r_wrIdx;
    logic [c_IDX_W-1:0]    r_rdIdx;
    logic [DATA_W-1:0]     r_ctrlShift;
    logic [7:0]            r_aud [c_P];
    logic [c_FILL_W-1:0]   r_fill;
    logic                  r_audPend;
    logic [SEQ_W-1:0]      r_seqCtrl;
    logic [SEQ_W-1:0]      r_seqAud;
    logic                  r_commit;
    logic [c_CNT_W-1:0]    r_pktCount;
`ifdef TRANSPORT_CHECKSUM_EN
    logic [7:0]            r_csum;
`endif

    logic                  w_inFire, w_ctrlFire, w_audFire;
    logic [c_FILL_W-1:0]   w_fillNext;
    logic                  w_audFull;
    logic                  w_room;
    logic [c_FCNT_W-1:0]   w_free;
    logic [c_FCNT_W-1:0]   w_fifoCount;
    logic                  w_fifoEmpty, w_fifoFull;
    logic                  w_fifoWr, w_fifoRd;
    logic [7:0]            w_fifoWrData, w_fifoHead;
    logic [7:0]            w_payload;
    logic                  w_wrLast;
    logic                  w_sopFire;

    sync_fifo_fwft #(
        .DEPTH (FIFO_BYTES),
        .WIDTH (8)
    ) u_fifo (
        .clk      (clk),
        .srst     (reset),
        .i_wrEn   (w_fifoWr),
        .i_wrData (w_fifoWrData),
        .i_rdEn   (w_fifoRd),
        .o_rdData (w_fifoHead),
        .o_empty  (w_fifoEmpty),
        .o_full   (w_fifoFull),
        .o_count  (w_fifoCount)
    );

    // A whole packet's worth of space is reserved before a packet is begun,
    // so the writer never stalls part-way through a packet.
    assign w_free     = c_FCNT_W'(FIFO_BYTES) - w_fifoCount;
    assign w_room     = !w_fifoFull && (w_free >= c_FCNT_W'(PKT_BYTES));
    assign in_ready   = (r_wstate == W_IDLE) && !r_audPend && w_room;
    assign w_inFire   = in_valid && in_ready;
    assign w_ctrlFire = w_inFire && (in_type == TYPE_CTRL);
    assign w_audFire  = w_inFire && (in_type == TYPE_AUDIO);

    // Audio packet closes when full, or when the next word would not fit.
    assign w_fillNext = w_audFire ? r_fill + c_FILL_W'(c_WB) : r_fill;
    assign w_audFull  = (w_fillNext == c_FILL_W'(c_P)) ||
                        ((c_FILL_W'(c_P) - w_fillNext) < c_FILL_W'(c_WB));

    assign busy       = (r_wstate != W_IDLE) || r_audPend;

    // Writer state register.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_wstate <= W_IDLE;
        end else begin
            r_wstate <= w_wnext;
        end
    end

    // Writer next state and the byte pushed into the FIFO each cycle.
    always_comb begin
        w_wnext      = r_wstate;
        w_fifoWr     = 1'b0;
        w_fifoWrData = '0;
        w_wrLast     = 1'b0;
        w_payload    = (r_wstate == W_CTRL) ? r_ctrlShift[DATA_W-1 -: 8] : r_aud[0];
        case (r_wstate)
            W_IDLE: begin
                if (r_audPend && w_room) begin
                    w_wnext = W_ACOPY;
                end else if (w_ctrlFire) begin
                    w_wnext = W_CTRL;
                end
            end
            W_CTRL, W_ACOPY: begin
                w_fifoWr = 1'b1;
                if (r_wrIdx == '0) begin
                    w_fifoWrData = (r_wstate == W_CTRL) ? makeHeader(TYPE_CTRL, r_seqCtrl)
                                                        : makeHeader(TYPE_AUDIO, r_seqAud);
`ifdef TRANSPORT_CHECKSUM_EN
                end else if (r_wrIdx == c_LAST_IDX) begin
                    w_fifoWrData = r_csum;
`endif
                end else begin
                    w_fifoWrData = w_payload;
                end
                if (r_wrIdx == c_LAST_IDX) begin
                    w_wrLast = 1'b1;
                    w_wnext  = W_IDLE;
                end
            end
            default: w_wnext = W_IDLE;
        endcase
    end

    // Writer datapath: byte index, control word shifter, sequence numbers.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_wrIdx     <= '0;
            r_ctrlShift <= '0;
            r_seqCtrl   <= '0;
            r_seqAud    <= '0;
            r_commit    <= 1'b0;
        end else begin
            if (r_wstate == W_IDLE || w_wrLast) begin
                r_wrIdx <= '0;
            end else begin
                r_wrIdx <= r_wrIdx + c_IDX_W'(1);
            end
            // The shifter drains MSB byte first and fills with zero, which
            // doubles as the pad after the word is exhausted.
            if (w_ctrlFire) begin
                r_ctrlShift <= in_data;
            end else if (r_wstate == W_CTRL && r_wrIdx != '0) begin
                r_ctrlShift <= r_ctrlShift << 8;
            end
            if (w_wrLast && r_wstate == W_CTRL) begin
                r_seqCtrl <= r_seqCtrl + SEQ_W'(1);
            end
            if (w_wrLast && r_wstate == W_ACOPY) begin
                r_seqAud <= r_seqAud + SEQ_W'(1);
            end
            r_commit <= w_wrLast;
        end
    end

`ifdef TRANSPORT_CHECKSUM_EN
    // Running XOR over the bytes of the packet being written.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_csum <= '0;
        end else if (w_fifoWr) begin
            r_csum <= (r_wrIdx == '0) ? w_fifoWrData : (r_csum ^ w_fifoWrData);
        end
    end
`endif

    // Audio assembly buffer: append words, close packets, drain on copy.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int k = 0; k < c_P; k++) begin
                r_aud[k] <= '0;
            end
            r_fill    <= '0;
            r_audPend <= 1'b0;
        end else if (r_wstate == W_ACOPY) begin
            // Shifting zeros in leaves the buffer clear once the copy ends.
            if (r_wrIdx != '0 && int'(r_wrIdx) <= c_P) begin
                for (int k = 0; k < c_P - 1; k++) begin
                    r_aud[k] <= r_aud[k+1];
                end
                r_aud[c_P-1] <= '0;
            end
            if (w_wrLast) begin
                r_fill    <= '0;
                r_audPend <= 1'b0;
            end
        end else begin
            if (w_audFire) begin
                for (int k = 0; k < c_P; k++) begin
                    for (int i = 0; i < c_WB; i++) begin
                        if (k == int'(r_fill) + i) begin
                            r_aud[k] <= in_data[DATA_W-1-8*i -: 8];
                        end
                    end
                end
                r_fill <= w_fillNext;
            end
            // A word arriving with flush is appended first, then closed.
            if ((w_audFire && w_audFull) || (audio_flush && w_fillNext != '0)) begin
                r_audPend <= 1'b1;
            end
        end
    end

    // Queued-packet counter: +1 after a packet is fully written, -1 on start.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_pktCount <= '0;
        end else begin
            case ({r_commit, w_sopFire})
                2'b10:   r_pktCount <= r_pktCount + c_CNT_W'(1);
                2'b01:   r_pktCount <= r_pktCount - c_CNT_W'(1);
                default: r_pktCount <= r_pktCount;
            endcase
        end
    end

    assign pkt_count = r_pktCount;

    // Reader state register.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_rstate <= R_IDLE;
        end else begin
            r_rstate <= w_rnext;
        end
    end

    // Reader next state: tx_en only gates the start of a packet.
    always_comb begin
        w_rnext = r_rstate;
        case (r_rstate)
            R_IDLE:  if (r_pktCount != '0 && tx_en) w_rnext = R_SEND;
            R_SEND:  if (out_ready && r_rdIdx == c_LAST_IDX) w_rnext = R_IDLE;
            default: w_rnext = R_IDLE;
        endcase
    end

    // Reader byte index within the packet being streamed.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_rdIdx <= '0;
        end else if (r_rstate != R_SEND) begin
            r_rdIdx <= '0;
        end else if (out_ready) begin
            r_rdIdx <= (r_rdIdx == c_LAST_IDX) ? '0 : r_rdIdx + c_IDX_W'(1);
        end
    end

    assign out_valid = (r_rstate == R_SEND);
    assign out_data  = out_valid ? w_fifoHead : 8'h00;
    assign out_sop   = out_valid && (r_rdIdx == '0);
    assign out_eop   = out_valid && (r_rdIdx == c_LAST_IDX);
    assign w_fifoRd  = out_valid && out_ready && !w_fifoEmpty;
    assign w_sopFire = out_sop && out_ready;

endmodule
`default_nettype wire

// File: tb/tb_transport_packetizer.sv
`default_nettype none
// ============================================================================
// Module   : tb_transport_packetizer
// Brief    : Self-checking bench: a packet-level reference model builds the
//            expected byte stream; a negedge monitor compares every accepted
//            output byte plus data hold under backpressure.
// Revision : 1.0  initial release
// ============================================================================
module tb_transport_packetizer;

    localparam int PKT_BYTES  = 16;
    localparam int DATA_W     = 16;
    localparam int FIFO_BYTES = 256;
    localparam int WB         = DATA_W / 8;
`ifdef TRANSPORT_CHECKSUM_EN
    localparam int P = PKT_BYTES - 2;
`else
    localparam int P = PKT_BYTES - 1;
`endif

    logic              clk;
    logic              reset;
    logic              in_valid;
    logic              in_ready;
    logic [1:0]        in_type;
    logic [DATA_W-1:0] in_data;
    logic              audio_flush;
    logic              tx_en;
    logic [7:0]        out_data;
    logic              out_valid;
    logic              out_ready;
    logic              out_sop;
    logic              out_eop;
    logic [4:0]        pkt_count;
    logic              busy;

    transport_packetizer #(
        .PKT_BYTES  (PKT_BYTES),
        .DATA_W     (DATA_W),
        .FIFO_BYTES (FIFO_BYTES)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_type     (in_type),
        .in_data     (in_data),
        .audio_flush (audio_flush),
        .tx_en       (tx_en),
        .out_data    (out_data),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_sop     (out_sop),
        .out_eop     (out_eop),
        .pkt_count   (pkt_count),
        .busy        (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Expected stream entries: {sop, eop, data}.
    logic [9:0] expQ[$];
    logic [7:0] obsLog[$];
    logic [7:0] audBuf[$];
    int         seqC = 0;
    int         seqA = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic failNow(input string name);
        checks++;
        errors++;
        $display("FAIL %s: timed out", name);
    endtask

    // ---------------- reference model (packet level) ----------------
    function automatic void pushPkt(input logic [7:0] hdr, input logic [7:0] pl[$]);
        logic [7:0] b[$];
        logic [7:0] x;
        b.push_back(hdr);
        foreach (pl[i]) b.push_back(pl[i]);
        while (b.size() < P + 1) b.push_back(8'h00);
`ifdef TRANSPORT_CHECKSUM_EN
        x = 8'h00;
        foreach (b[i]) x = x ^ b[i];
        b.push_back(x);
`else
        x = 8'h00;
`endif
        foreach (b[i]) expQ.push_back({(i == 0), (i == PKT_BYTES - 1), b[i]});
    endfunction

    function automatic void closeAudio();
        pushPkt({2'b10, 6'(seqA)}, audBuf);
        seqA = (seqA + 1) % 64;
        audBuf.delete();
    endfunction

    function automatic void modelWord(input logic [1:0] t, input logic [15:0] d, input logic fl);
        logic [7:0] pl[$];
        if (t == 2'b01) begin
            pl.push_back(d[15:8]);
            pl.push_back(d[7:0]);
            pushPkt({2'b01, 6'(seqC)}, pl);
            seqC = (seqC + 1) % 64;
        end else if (t == 2'b10) begin
            audBuf.push_back(d[15:8]);
            audBuf.push_back(d[7:0]);
            if (audBuf.size() == P || (P - audBuf.size()) < WB) closeAudio();
        end
        if (fl && audBuf.size() > 0) closeAudio();
    endfunction

    // ---------------- output monitor ----------------
    logic [7:0] prevData;
    logic       prevStall = 1'b0;

    always @(negedge clk) begin : monitor
        logic [9:0] e;
        if (reset) begin
            prevStall = 1'b0;
        end else begin
            if (prevStall) begin
                check("hold_valid", out_valid, 1'b1);
                check("hold_data", out_data, prevData);
            end
            prevStall = out_valid && !out_ready;
            prevData  = out_data;
            if (out_valid && out_ready) begin
                if (expQ.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_byte: got %0h expected no byte", out_data);
                end else begin
                    e = expQ.pop_front();
                    check("stream_byte", {out_sop, out_eop, out_data}, e);
                end
                obsLog.push_back(out_data);
            end
        end
    end

    // ---------------- drivers ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic doReset();
        reset = 1'b1;
        expQ.delete();
        audBuf.delete();
        obsLog.delete();
        seqC = 0;
        seqA = 0;
        tick();
        tick();
        reset = 1'b0;
    endtask

    task automatic sendWord(input logic [1:0] t, input logic [15:0] d, input logic fl);
        int n;
        n = 0;
        in_valid    = 1'b1;
        in_type     = t;
        in_data     = d;
        audio_flush = fl;
        @(negedge clk);
        while (!in_ready && n < 2000) begin
            n++;
            @(negedge clk);
        end
        if (!in_ready) failNow("accept_timeout");
        else modelWord(t, d, fl);
        tick();
        in_valid    = 1'b0;
        audio_flush = 1'b0;
    endtask

    task automatic flushPulse();
        audio_flush = 1'b1;
        tick();
        audio_flush = 1'b0;
        if (audBuf.size() > 0) closeAudio();
    endtask

    task automatic waitDrain(input bit toggleReady);
        int n;
        n = 0;
        while (expQ.size() != 0 && n < 10000) begin
            if (toggleReady) out_ready = 1'($urandom_range(0, 1));
            tick();
            n++;
        end
        out_ready = 1'b1;
        if (expQ.size() != 0) failNow("drain_timeout");
        repeat (5) tick();
    endtask

    // ---------------- directed tests ----------------
    initial begin : stim
        int n;
        reset = 1'b1; in_valid = 1'b0; in_type = 2'b00; in_data = '0;
        audio_flush = 1'b0; tx_en = 1'b1; out_ready = 1'b1;
        doReset();

        // Reset state
        check("rst_out_valid", out_valid, 1'b0);
        check("rst_out_sop", out_sop, 1'b0);
        check("rst_out_eop", out_eop, 1'b0);
        check("rst_out_data", out_data, 8'h00);
        check("rst_pkt_count", pkt_count, 5'd0);
        check("rst_busy", busy, 1'b0);
        check("rst_in_ready", in_ready, 1'b1);

        // Single control packet
        sendWord(2'b01, 16'hABCD, 1'b0);
        check("ctrl_busy", busy, 1'b1);
        waitDrain(1'b0);
        check("ctrl_len", obsLog.size(), 16);
        check("ctrl_hdr", obsLog[0], 8'h40);
        check("ctrl_b1", obsLog[1], 8'hAB);
        check("ctrl_b2", obsLog[2], 8'hCD);
        check("ctrl_pad", obsLog[3], 8'h00);
`ifndef TRANSPORT_CHECKSUM_EN
        check("ctrl_last", obsLog[15], 8'h00);
`endif
        check("ctrl_idle_valid", out_valid, 1'b0);

        // Seven audio words close a packet; eighth starts seq 1
        doReset();
        for (int i = 1; i <= 7; i++) sendWord(2'b10, 16'(i), 1'b0);
        waitDrain(1'b0);
        check("aud_hdr", obsLog[0], 8'h80);
        check("aud_w1", obsLog[2], 8'h01);
        check("aud_w7", obsLog[14], 8'h07);
`ifndef TRANSPORT_CHECKSUM_EN
        check("aud_pad", obsLog[15], 8'h00);
`endif
        sendWord(2'b10, 16'h0008, 1'b0);
        check("aud_partial_busy", busy, 1'b0);
        check("aud_partial_cnt", pkt_count, 5'd0);
        flushPulse();
        waitDrain(1'b0);
        check("aud_hdr2", obsLog[16], 8'h81);
        check("aud_w8", obsLog[18], 8'h08);

        // Flush behaviour
        doReset();
        sendWord(2'b10, 16'h1234, 1'b0);
        flushPulse();
        waitDrain(1'b0);
        check("flush_hdr", obsLog[0], 8'h80);
        check("flush_b1", obsLog[1], 8'h12);
        check("flush_b2", obsLog[2], 8'h34);
        check("flush_pad", obsLog[3], 8'h00);
        sendWord(2'b10, 16'h5678, 1'b1);
        waitDrain(1'b0);
        check("wflush_hdr", obsLog[16], 8'h81);
        check("wflush_b1", obsLog[17], 8'h56);
        flushPulse();
        repeat (30) tick();
        check("empty_flush_cnt", pkt_count, 5'd0);
        check("empty_flush_busy", busy, 1'b0);

        // Reserved types are accepted and dropped
        sendWord(2'b00, 16'hDEAD, 1'b0);
        sendWord(2'b11, 16'hBEEF, 1'b0);
        repeat (30) tick();
        check("resv_in_ready", in_ready, 1'b1);
        check("resv_busy", busy, 1'b0);
        check("resv_cnt", pkt_count, 5'd0);

        // Fill the FIFO with tx_en low, then drain under backpressure
        doReset();
        tx_en = 1'b0;
        for (int i = 0; i < 16; i++) sendWord(2'b01, 16'(i * 16'h0101), 1'b0);
        repeat (20) tick();
        check("full_cnt", pkt_count, 5'd16);
        check("full_in_ready", in_ready, 1'b0);
        check("full_out_valid", out_valid, 1'b0);
        tx_en = 1'b1;
        waitDrain(1'b1);
        check("bp_len", obsLog.size(), 256);
        check("bp_hdr15", obsLog[15*16], 8'h4F);
        check("bp_cnt", pkt_count, 5'd0);

        // Sequence wrap 63 -> 0
        doReset();
        for (int i = 0; i < 65; i++) sendWord(2'b01, 16'(i), 1'b0);
        waitDrain(1'b0);
        check("wrap_hdr63", obsLog[63*16], 8'h7F);
        check("wrap_hdr64", obsLog[64*16], 8'h40);

        // Reset while the fifth byte of a packet is on the link
        doReset();
        tx_en = 1'b0;
        sendWord(2'b01, 16'hAAAA, 1'b0);
        sendWord(2'b01, 16'hBBBB, 1'b0);
        repeat (20) tick();
        tx_en = 1'b1;
        n = 0;
        while (obsLog.size() < 4 && n < 500) begin
            tick();
            n++;
        end
        if (obsLog.size() < 4) failNow("midreset_wait");
        reset = 1'b1;
        expQ.delete(); audBuf.delete(); obsLog.delete();
        seqC = 0; seqA = 0;
        tick();
        tick();
        check("midrst_valid", out_valid, 1'b0);
        check("midrst_cnt", pkt_count, 5'd0);
        reset = 1'b0;
        repeat (30) tick();
        check("midrst_nothing", obsLog.size(), 0);
        sendWord(2'b01, 16'h1111, 1'b0);
        waitDrain(1'b0);
        check("midrst_hdr", obsLog[0], 8'h40);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
